// File: rtl/alu_issue_stage.sv
// Issue/writeback stage feeding an external 8-bit combinational ALU: regfile, 3-cycle issue FSM, host load, debug read.
// Optional macro ALU_FLAGS_EN adds zero/sign flags captured at writeback.
module alu_issue_stage #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned REG_ADDR_W = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        instr_valid,
    output logic                        instr_ready,
    input  logic [3+3*REG_ADDR_W-1:0]   instr,
    input  logic                        ld_en,
    input  logic [REG_ADDR_W-1:0]       ld_addr,
    input  logic [DATA_W-1:0]           ld_data,
    output logic [DATA_W-1:0]           alu_data1,
    output logic [DATA_W-1:0]           alu_data2,
    output logic [2:0]                  alu_opcode,
    input  logic [DATA_W-1:0]           alu_result,
    output logic                        wb_valid,
    output logic [REG_ADDR_W-1:0]       wb_addr,
    output logic [DATA_W-1:0]           wb_data,
    input  logic [REG_ADDR_W-1:0]       dbg_addr,
    output logic [DATA_W-1:0]           dbg_data,
    output logic                        flag_z,
    output logic                        flag_n
);

    localparam int unsigned NREGS   = 1 << REG_ADDR_W;
    localparam int unsigned RA      = REG_ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [DATA_W-1:0]      rf_q [NREGS];
    logic [DATA_W-1:0]      rf_d [NREGS];
    logic [DATA_W-1:0]      alu_data1_q, alu_data1_d;
    logic [DATA_W-1:0]      alu_data2_q, alu_data2_d;
    logic [2:0]             alu_opcode_q, alu_opcode_d;
    logic [RA-1:0]          rd_q, rd_d;
    logic [DATA_W-1:0]      result_q, result_d;
    logic                   wb_valid_q, wb_valid_d;
    logic [RA-1:0]          wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0]      wb_data_q, wb_data_d;

    logic [2:0]             instr_op;
    logic [RA-1:0]          instr_rd, instr_rs1, instr_rs2;

    assign instr_rs2 = instr[RA-1:0];
    assign instr_rs1 = instr[2*RA-1:RA];
    assign instr_rd  = instr[3*RA-1:2*RA];
    assign instr_op  = instr[3*RA+2:3*RA];

    // Host load wins over issue in IDLE, so ready drops combinationally with ld_en.
    assign instr_ready = (state_q == S_IDLE) && !ld_en;
    assign dbg_data    = rf_q[dbg_addr];

    assign alu_data1  = alu_data1_q;
    assign alu_data2  = alu_data2_q;
    assign alu_opcode = alu_opcode_q;
    assign wb_valid   = wb_valid_q;
    assign wb_addr    = wb_addr_q;
    assign wb_data    = wb_data_q;

`ifdef ALU_FLAGS_EN
    logic flag_z_q, flag_z_d;
    logic flag_n_q, flag_n_d;
    assign flag_z = flag_z_q;
    assign flag_n = flag_n_q;
`else
    assign flag_z = 1'b0;
    assign flag_n = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        rf_d         = rf_q;
        alu_data1_d  = alu_data1_q;
        alu_data2_d  = alu_data2_q;
        alu_opcode_d = alu_opcode_q;
        rd_d         = rd_q;
        result_d     = result_q;
        wb_valid_d   = 1'b0;
        wb_addr_d    = wb_addr_q;
        wb_data_d    = wb_data_q;
`ifdef ALU_FLAGS_EN
        flag_z_d     = flag_z_q;
        flag_n_d     = flag_n_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ld_en) begin
                    rf_d[ld_addr] = ld_data;
                end else if (instr_valid) begin
                    alu_data1_d  = rf_q[instr_rs1];
                    alu_data2_d  = rf_q[instr_rs2];
                    alu_opcode_d = instr_op;
                    rd_d         = instr_rd;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                result_d = alu_result;
                state_d  = S_WB;
            end
            S_WB: begin
                rf_d[rd_q] = result_q;
                wb_valid_d = 1'b1;
                wb_addr_d  = rd_q;
                wb_data_d  = result_q;
`ifdef ALU_FLAGS_EN
                flag_z_d   = (result_q == '0);
                flag_n_d   = result_q[DATA_W-1];
`endif
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
            alu_data1_q  <= '0;
            alu_data2_q  <= '0;
            alu_opcode_q <= '0;
            rd_q         <= '0;
            result_q     <= '0;
            wb_valid_q   <= 1'b0;
            wb_addr_q    <= '0;
            wb_data_q    <= '0;
`ifdef ALU_FLAGS_EN
            flag_z_q     <= 1'b0;
            flag_n_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            rf_q         <= rf_d;
            alu_data1_q  <= alu_data1_d;
            alu_data2_q  <= alu_data2_d;
            alu_opcode_q <= alu_opcode_d;
            rd_q         <= rd_d;
            result_q     <= result_d;
            wb_valid_q   <= wb_valid_d;
            wb_addr_q    <= wb_addr_d;
            wb_data_q    <= wb_data_d;
`ifdef ALU_FLAGS_EN
            flag_z_q     <= flag_z_d;
            flag_n_q     <= flag_n_d;
`endif
        end
    end

endmodule
